// File: rtl/fifo_pkt_reader_if.sv
// Bundle for the reader's FIFO-side and formatter-side handshake signals.
// The DUT connects through the master modport. The FIFO/arbiter/formatter environment connects through slave.
// Optional macro PKT_CHKSUM_EN adds the fmt_chksum_o signal.
interface fifo_pkt_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // FIFO side
    logic [DATA_W-1:0] fifo_data_i;
    logic              fifo_empty_i;
    logic [ADDR_W:0]   fifo_freeslot_i;
    logic              fifo_rd_o;

    // Arbiter / formatter side
    logic              fmt_req_o;
    logic              fmt_grant_i;
    logic              fmt_valid_o;
    logic              fmt_ready_i;
    logic [DATA_W-1:0] fmt_data_o;
    logic              fmt_start_o;
    logic              fmt_end_o;
`ifdef PKT_CHKSUM_EN
    logic [DATA_W-1:0] fmt_chksum_o;
`endif

    modport master (
`ifdef PKT_CHKSUM_EN
        output fmt_chksum_o,
`endif
        input  fifo_data_i, fifo_empty_i, fifo_freeslot_i, fmt_grant_i, fmt_ready_i,
        output fifo_rd_o, fmt_req_o, fmt_valid_o, fmt_data_o, fmt_start_o, fmt_end_o
    );

    modport slave (
`ifdef PKT_CHKSUM_EN
        input  fmt_chksum_o,
`endif
        output fifo_data_i, fifo_empty_i, fifo_freeslot_i, fmt_grant_i, fmt_ready_i,
        input  fifo_rd_o, fmt_req_o, fmt_valid_o, fmt_data_o, fmt_start_o, fmt_end_o
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drain-side packet reader for one channel FIFO.
// It waits until a full packet is buffered and then requests the arbiter.
// After the grant, it pops exactly one packet onto the valid/ready formatter port.
// The first beat is marked with start and the last beat with end.
// Optional macro PKT_CHKSUM_EN adds fmt_chksum_o, which is the XOR of the packet words.
// fmt_chksum_o is presented on the end beat.
module fifo_pkt_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [1:0]           len_sel_i,
    output logic                 underrun_o,
    output logic                 idle_o,
    fifo_pkt_reader_if.master    bus
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] sel_len;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_valid;
    logic             beat_last;
    logic             beat_xfer;

    // Packet length select: 0->4, 1->8, 2->16, 3->32 words.
    function automatic logic [CNT_W-1:0] pkt_len(input logic [1:0] sel);
        return CNT_W'(4) << sel;
    endfunction

    // Words currently buffered in the FIFO (0..DEPTH).
    assign level   = CNT_W'(DEPTH) - bus.fifo_freeslot_i;
    assign sel_len = pkt_len(len_sel_i);
    assign idle_o  = (state == ST_IDLE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and the packet-side outputs.
    // NOTE: every output is defaulted first so no path through the case leaves a latch.
    always_comb begin
        state_nxt       = state;
        bus.fmt_req_o   = 1'b0;
        beat_valid      = 1'b0;
        beat_last       = 1'b0;
        beat_xfer       = 1'b0;
        bus.fmt_data_o  = {DATA_W{1'b0}};
        bus.fmt_start_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level >= sel_len) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                bus.fmt_req_o = 1'b1;
                if (bus.fmt_grant_i) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                beat_valid      = !bus.fifo_empty_i;
                bus.fmt_data_o  = bus.fifo_data_i;
                bus.fmt_start_o = beat_valid && (beat_cnt == '0);
                beat_last       = beat_valid && (beat_cnt == len_r - 1'b1);
                beat_xfer       = beat_valid && bus.fmt_ready_i;
                if (beat_xfer && beat_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.fmt_valid_o = beat_valid;
    assign bus.fmt_end_o   = beat_last;
    assign bus.fifo_rd_o   = beat_xfer;

    // Latch the packet length on IDLE->REQ and count transferred beats during SEND.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_r    <= CNT_W'(4);
            beat_cnt <= '0;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_REQ) len_r <= sel_len;
            if (state == ST_REQ && bus.fmt_grant_i)      beat_cnt <= '0;
            else if (beat_xfer)                          beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Sticky underrun: the FIFO ran dry while beats of a granted packet were still owed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                                    underrun_o <= 1'b0;
        else if (state == ST_SEND && bus.fifo_empty_i)   underrun_o <= 1'b1;
    end

`ifdef PKT_CHKSUM_EN
    logic [DATA_W-1:0] chk_acc;

    // Running XOR of the words transferred so far in this packet; cleared on the grant edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                                 chk_acc <= '0;
        else if (state == ST_REQ && bus.fmt_grant_i)  chk_acc <= '0;
        else if (beat_xfer)                           chk_acc <= chk_acc ^ bus.fifo_data_i;
    end

    // The end beat folds in its own word, so the output is the XOR of the whole packet.
    assign bus.fmt_chksum_o = beat_last ? (chk_acc ^ bus.fifo_data_i) : {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader.
// A queue models the channel FIFO contents, and each packet is checked against the rule that a packet
// is the next N words of that queue in order.
// The bench also checks the packet length latched when the request rises, the start/end markers,
// pop strobes, underrun and reset behaviour.
// Define PKT_CHKSUM_EN to also check fmt_chksum_o.
module tb_fifo_pkt_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [1:0] len_sel_i;
    logic       underrun_o;
    logic       idle_o;

    fifo_pkt_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_pkt_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .len_sel_i  (len_sel_i),
        .underrun_o (underrun_o),
        .idle_o     (idle_o),
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [DATA_W-1:0] fifo_q[$];
    bit                hide_empty  = 1'b0;
    bit                pattern_mode = 1'b0;
    int                word_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present the model FIFO to the DUT: head word, empty flag, free slots.
    task automatic drive_fifo();
        bus.fifo_data_i     = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
        bus.fifo_empty_i    = hide_empty || (fifo_q.size() == 0);
        bus.fifo_freeslot_i = (ADDR_W+1)'(DEPTH - fifo_q.size());
    endtask

    task automatic push_word();
        logic [DATA_W-1:0] w;
        if (fifo_q.size() < DEPTH) begin
            w = pattern_mode ? (DATA_W'(1) << word_idx) : DATA_W'($urandom);
            word_idx++;
            fifo_q.push_back(w);
            drive_fifo();
        end
    endtask

    // Let combinational outputs settle, record the pop strobe, advance one clock.
    // Then re-present the FIFO at the falling edge.
    task automatic tick();
        bit pop;
        #1;
        pop = bus.fifo_rd_o;
        @(posedge clk_i);
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clk_i);
        drive_fifo();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   bus.fmt_req_o,   0);
        check({tag, "_valid"}, bus.fmt_valid_o, 0);
        check({tag, "_rd"},    bus.fifo_rd_o,   0);
        check({tag, "_start"}, bus.fmt_start_o, 0);
        check({tag, "_end"},   bus.fmt_end_o,   0);
        check({tag, "_data"},  bus.fmt_data_o,  0);
`ifdef PKT_CHKSUM_EN
        check({tag, "_chk"},   bus.fmt_chksum_o, 0);
`endif
    endtask

    // One packet from IDLE through REQ and SEND back to IDLE.
    // stall_beat >= 0 holds ready low for 3 cycles at that beat.
    // req_sel is applied to len_sel_i while the request is pending.
    task automatic run_packet(input int sel, input int stall_beat, input int req_sel);
        int                len;
        int                beats;
        int                budget;
        int                stall;
        int                waitc;
        logic [DATA_W-1:0] xacc;
        len   = 4 << sel;
        beats = 0;
        stall = 0;
        xacc  = '0;
        len_sel_i = 2'(sel);
        bus.fmt_ready_i = 1'($urandom_range(0, 1));
        #1;
        check("idle_before", idle_o, 1);
        check_quiet("idle");
        if (fifo_q.size() < len) begin
            // One word short of a packet: no request, and stray grants are ignored.
            while (fifo_q.size() < len - 1) push_word();
            repeat (2) begin
                bus.fmt_grant_i = 1'($urandom_range(0, 1));
                #1;
                check("short_req", bus.fmt_req_o, 0);
                check("short_valid", bus.fmt_valid_o, 0);
                tick();
            end
            bus.fmt_grant_i = 1'b0;
            check("short_idle", idle_o, 1);
            push_word();
        end
        tick();
        check("req_up", bus.fmt_req_o, 1);
        check("req_idle", idle_o, 0);
        check("req_valid", bus.fmt_valid_o, 0);
        check("req_rd", bus.fifo_rd_o, 0);
        len_sel_i = 2'(req_sel);
        waitc = $urandom_range(0, 3);
        repeat (waitc) begin
            tick();
            check("req_held", bus.fmt_req_o, 1);
        end
        bus.fmt_grant_i = 1'b1;
        tick();
        bus.fmt_grant_i = 1'b0;
        #1;
        check("send_req", bus.fmt_req_o, 0);
        budget = 0;
        while (beats < len && budget < 400) begin
            budget++;
            if (beats == stall_beat && stall < 3) begin
                bus.fmt_ready_i = 1'b0;
                stall++;
            end else begin
                bus.fmt_ready_i = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 3) == 0) push_word();
            #1;
            check("beat_valid", bus.fmt_valid_o, 1);
            check("beat_data",  bus.fmt_data_o,  fifo_q[0]);
            check("beat_start", bus.fmt_start_o, (beats == 0));
            check("beat_end",   bus.fmt_end_o,   (beats == len - 1));
            check("beat_rd",    bus.fifo_rd_o,   bus.fmt_ready_i);
`ifdef PKT_CHKSUM_EN
            check("beat_chk", bus.fmt_chksum_o, (beats == len - 1) ? (xacc ^ fifo_q[0]) : '0);
`endif
            if (bus.fmt_ready_i) begin
                xacc ^= fifo_q[0];
                beats++;
            end
            tick();
        end
        if (beats < len) check("send_timeout", beats, len);
        bus.fmt_ready_i = 1'($urandom_range(0, 1));
        #1;
        check("idle_after", idle_o, 1);
        check_quiet("after");
        check("underrun_clean", underrun_o, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i         = 1'b0;
        len_sel_i       = 2'd0;
        bus.fmt_grant_i = 1'b0;
        bus.fmt_ready_i = 1'b0;
        drive_fifo();
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_idle", idle_o, 1);
        check("rst_underrun", underrun_o, 0);
        check_quiet("rst");
        rst_n_i = 1'b1;
        tick();
        check("post_rst_idle", idle_o, 1);
        check("post_rst_freeslot_empty", bus.fmt_req_o, 0);

        // Directed packets from the test plan, then a random mix.
        run_packet(0, -1, 0);
        run_packet(3, -1, 1);
        run_packet(1, 2, 0);
        run_packet(0, -1, 3);
        for (int i = 0; i < 20; i++)
            run_packet($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
                       $urandom_range(0, 3));

        // Underrun during a 4-word packet, then reset mid-SEND.
        fifo_q.delete();
        drive_fifo();
        len_sel_i = 2'd0;
        repeat (4) push_word();
        tick();
        check("ur_req", bus.fmt_req_o, 1);
        bus.fmt_grant_i = 1'b1;
        tick();
        bus.fmt_grant_i = 1'b0;
        bus.fmt_ready_i = 1'b1;
        #1;
        check("ur_beat0_start", bus.fmt_start_o, 1);
        tick();
        hide_empty = 1'b1;
        drive_fifo();
        #1;
        check("ur_valid_drop", bus.fmt_valid_o, 0);
        check("ur_no_pop", bus.fifo_rd_o, 0);
        check("ur_not_yet", underrun_o, 0);
        tick();
        check("ur_set", underrun_o, 1);
        check("ur_still_send", idle_o, 0);
        hide_empty = 1'b0;
        drive_fifo();
        #1;
        check("ur_resume_valid", bus.fmt_valid_o, 1);
        check("ur_resume_data", bus.fmt_data_o, fifo_q[0]);
        check("ur_resume_start", bus.fmt_start_o, 0);
        tick();
        check("ur_sticky", underrun_o, 1);
        rst_n_i = 1'b0;
        #1;
        check("abort_idle", idle_o, 1);
        check("abort_underrun", underrun_o, 0);
        check_quiet("abort");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        fifo_q.delete();
        drive_fifo();
        #1;

        // Single-bit words 0x1,0x2,0x4,0x8: end-beat checksum is 0xF.
        pattern_mode = 1'b1;
        word_idx     = 0;
        run_packet(0, -1, 0);
        pattern_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
